// File: rtl/seq_alu_core_if.sv
// -----------------------------------------------------------------------------
// seq_alu_core_if
//   Bundles the operand-side and result-side handshakes of seq_alu_core.
//
//   Handshake semantics (both channels):
//     A transfer happens on a rising clk edge where valid and ready are both 1.
//     The producer holds its valid and payload stable until that transfer edge.
//     The consumer may raise or drop ready at any time.
//
//   Signals
//     in_valid / in_ready : operand channel (source -> core)
//     a, b, op            : operands and 3-bit opcode
//     out_valid/out_ready : result channel (core -> sink)
//     result, cb, zero    : 2*WIDTH result, carry/borrow, zero flag
//     ovf                 : signed overflow, present only with ALU_OVF_EN
//
//   Modports
//     master : operand source plus result sink (drives in_*, out_ready)
//     slave  : the ALU core
//
//   Optional feature macro: ALU_OVF_EN
// -----------------------------------------------------------------------------
interface seq_alu_core_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 cb;
    logic                 zero;
`ifdef ALU_OVF_EN
    logic                 ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cb, zero, ovf
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cb, zero, ovf
    );
`else
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cb, zero
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cb, zero
    );
`endif
endinterface

// File: rtl/seq_alu_core.sv
// -----------------------------------------------------------------------------
// seq_alu_core
//   Clocked ALU with valid/ready handshakes on operand and result channels.
//   Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 SHL, 100 SHR, 101 AND, 110 OR,
//   111 XOR. Single-cycle ops register their result on the accept edge; MUL
//   runs an LSB-first shift-add engine for WIDTH cycles. A finished result is
//   held in DONE until the sink takes it; a new op can be accepted on that
//   same edge.
//
//   Ports
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : seq_alu_core_if.slave (operand + result handshakes)
//     state_o  : current FSM state (0 IDLE, 1 MUL, 2 DONE) for observation
//
//   Optional feature macro: ALU_OVF_EN (adds registered signed overflow flag)
// -----------------------------------------------------------------------------
module seq_alu_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_alu_core_if.slave        bus,
    output logic [1:0]           state_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 cb_q, cb_d;
    logic                 zero_q, zero_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
`ifdef ALU_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    logic                 accept;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     alu_lo;
    logic                 alu_cb;
    logic                 alu_ovf;
    logic [2*WIDTH-1:0]   mul_step;

    // DONE can hand its result to the sink and take a new op on the same edge.
    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.cb        = cb_q;
    assign bus.zero      = zero_q;
`ifdef ALU_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign state_o       = state_q;

    // Single-cycle datapath; ADD/SUB carry out of bit WIDTH is the cb flag.
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_lo  = '0;
        alu_cb  = 1'b0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_lo  = sum[WIDTH-1:0];
                alu_cb  = sum[WIDTH];
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo  = diff[WIDTH-1:0];
                alu_cb  = diff[WIDTH];
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            // The full b is the shift amount, so any b >= WIDTH clears the result.
            OP_SHL:  alu_lo = (bus.b >= WIDTH_V) ? '0 : (bus.a << bus.b);
            OP_SHR:  alu_lo = (bus.b >= WIDTH_V) ? '0 : (bus.a >> bus.b);
            OP_AND:  alu_lo = bus.a & bus.b;
            OP_OR:   alu_lo = bus.a | bus.b;
            OP_XOR:  alu_lo = bus.a ^ bus.b;
            default: alu_lo = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cb_d     = cb_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        // One partial product per cycle: add the shifted multiplicand when the
        // current multiplier LSB is set.
        mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = {{WIDTH{1'b0}}, alu_lo};
                        cb_d     = alu_cb;
                        zero_d   = (alu_lo == '0);
`ifdef ALU_OVF_EN
                        ovf_d    = alu_ovf;
`endif
                    end
                end else if (state_q == S_DONE && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = mul_step;
                    cb_d     = 1'b0;
                    zero_d   = (mul_step == '0);
                    cnt_d    = '0;
`ifdef ALU_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cb_q     <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`ifdef ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

`ifndef ALU_OVF_EN
    // Overflow term is only registered when the feature is built in.
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_seq_alu_core.sv
`timescale 1ns/1ps
module tb_seq_alu_core;
  localparam int W  = 8;
  localparam int EW = 2*W + 3;   // {ovf, cb, zero, result}

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  seq_alu_core_if #(.WIDTH(W)) bus ();

  seq_alu_core #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_model(input logic [2:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned ua, ub, m, res;
    longint sa, sb, half, s;
    logic c, ov;
    ua   = 64'(a);
    ub   = 64'(b);
    m    = 64'd1 << W;
    half = longint'(64'd1 << (W-1));
    sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(m) : longint'(ub);
    c    = 1'b0;
    ov   = 1'b0;
    res  = 0;
    case (op)
      3'd0: begin
        res = (ua + ub) % m;
        c   = (ua + ub) >= m;
        s   = sa + sb;
        ov  = (s > half - 1) || (s < -half);
      end
      3'd1: begin
        res = (ua + m - ub) % m;
        c   = ua < ub;
        s   = sa - sb;
        ov  = (s > half - 1) || (s < -half);
      end
      3'd2: res = ua * ub;
      3'd3: res = (ub >= 64'(W)) ? 0 : (ua * (64'd1 << ub)) % m;
      3'd4: res = (ub >= 64'(W)) ? 0 : ua / (64'd1 << ub);
      3'd5: res = ua & ub;
      3'd6: res = ua | ub;
      default: res = ua ^ ub;
    endcase
    return {ov, c, (res == 0), (2*W)'(res)};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", 64'(bus.result), 64'(mon_e[2*W-1:0]));
        check("sb_zero",   64'(bus.zero),   64'(mon_e[2*W]));
        check("sb_cb",     64'(bus.cb),     64'(mon_e[2*W+1]));
`ifdef ALU_OVF_EN
        check("sb_ovf",    64'(bus.ovf),    64'(mon_e[2*W+2]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard > 200) break;
      @(posedge clk); #1;
    end
    if (guard > 200) begin
      check("send_timeout", 64'(1), 64'(0));
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_model(op, a, b));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic lat_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [2*W-1:0] exp_res,
                        input logic exp_cb, input logic exp_zero);
    int n;
    int rdy_seen;
    send(op, a, b);
    n = 1;
    rdy_seen = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_seen++;
      if (n > 4*W + 10) break;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"},      64'(n),          64'(exp_lat));
    check({tag, "_busy_rdy"}, 64'(rdy_seen),   64'(0));
    check({tag, "_result"},   64'(bus.result), 64'(exp_res));
    check({tag, "_cb"},       64'(bus.cb),     64'(exp_cb));
    check({tag, "_zero"},     64'(bus.zero),   64'(exp_zero));
    @(posedge clk); #1;
  endtask

`ifdef ALU_OVF_EN
  task automatic ovf_case(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input logic exp_ovf);
    bus.out_ready = 1'b0;
    lat_op(tag, op, a, b, 1, exp_res, ref_model(op, a, b)[2*W+1], exp_res == '0);
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    int n_ops;
    int cyc;
    logic accepted;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 3'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result",    64'(bus.result),    64'(0));
    check("rst_cb",        64'(bus.cb),        64'(0));
    check("rst_zero",      64'(bus.zero),      64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_state",     64'(dbg_state),     64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    send(3'd2, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midmul_rst_result",    64'(bus.result),    64'(0));
    check("midmul_rst_in_ready",  64'(bus.in_ready),  64'(1));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    lat_op("post_rst_add", 3'd0, 8'd1, 8'd1, 1, 16'h0002, 1'b0, 1'b0);

    // Arithmetic.
    lat_op("add_200_100", 3'd0, 8'd200, 8'd100, 1, 16'h002C, 1'b1, 1'b0);
    lat_op("sub_3_5",     3'd1, 8'd3,   8'd5,   1, 16'h00FE, 1'b1, 1'b0);
    lat_op("sub_5_5",     3'd1, 8'd5,   8'd5,   1, 16'h0000, 1'b0, 1'b1);
    lat_op("mul_ff_ff",   3'd2, 8'hFF,  8'hFF,  W+1, 16'hFE01, 1'b0, 1'b0);
    lat_op("mul_0_ff",    3'd2, 8'h00,  8'hFF,  W+1, 16'h0000, 1'b0, 1'b1);

    // Shifts.
    lat_op("shl_81_1",   3'd3, 8'h81, 8'd1,   1, 16'h0002, 1'b0, 1'b0);
    lat_op("shr_80_7",   3'd4, 8'h80, 8'd7,   1, 16'h0001, 1'b0, 1'b0);
    lat_op("shl_by_8",   3'd3, 8'hFF, 8'd8,   1, 16'h0000, 1'b0, 1'b1);
    lat_op("shl_by_200", 3'd3, 8'hFF, 8'd200, 1, 16'h0000, 1'b0, 1'b1);
    lat_op("shr_by_8",   3'd4, 8'hFF, 8'd8,   1, 16'h0000, 1'b0, 1'b1);

`ifdef ALU_OVF_EN
    ovf_case("ovf_add_127_1", 3'd0, 8'd127, 8'd1, 16'h0080, 1'b1);
    ovf_case("ovf_sub_80_1",  3'd1, 8'h80,  8'd1, 16'h007F, 1'b1);
    ovf_case("ovf_add_1_1",   3'd0, 8'd1,   8'd1, 16'h0002, 1'b0);
`endif

    // Backpressure, then back-to-back accept on the release edge.
    bus.out_ready = 1'b0;
    send(3'd7, 8'hF0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_result",    64'(bus.result),    64'(16'h00CC));
      check("bp_in_ready",  64'(bus.in_ready),  64'(0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(3'd5, 8'hA5, 8'h0F);
    @(negedge clk);
    check("b2b_out_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_result",    64'(bus.result),    64'(16'h0005));
    @(posedge clk); #1;

    // Randomized traffic with a stalling sink.
    n_ops = 0;
    cyc   = 0;
    while (n_ops < 300 && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
        bus.op = 3'($urandom_range(0, 7));
        bus.a  = pick();
        bus.b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, W + 1)) : pick();
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) exp_q.push_back(ref_model(bus.op, bus.a, bus.b));
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        bus.in_valid = 1'b0;
        n_ops++;
      end
    end
    check("rand_ops_done", 64'(n_ops), 64'(300));

    // Drain outstanding results.
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty",     64'(exp_q.size()),  64'(0));
    check("final_out_valid", 64'(bus.out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
